ppu_vram_arbiter: RTL and testbench
===================================

Name: ppu_vram_arbiter

Overview:
- Single-port VRAM read arbiter for the PPU pixel pipeline.
- Shares one memory read port between three requesters:
  - sprite fetcher (highest priority)
  - background/window fetcher
  - CPU (lowest priority)
- Sequences exactly one outstanding read at a time, routes each response back to its owner, and enforces mode-3 CPU lockout and response timeout.
- Sits between the BG/sprite FIFO fetchers, the CPU bus and the VRAM BRAM wrapper.

Parameters:
- ADDR_WIDTH, 16, request/memory address width.
- DATA_WIDTH, 8, read data width.
- TIMEOUT, 16, cycles in BUSY without mem_valid_in before forced completion; must be ≥ 2.
- BLOCKED_DATA, 8'hFF, data returned for blocked CPU reads and timeouts.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- spr_req_in  input  1  sprite fetcher read request (level).
- spr_addr_in  input  ADDR_WIDTH  sprite request address.
- spr_ack_out  output  1  sprite request accepted (1-cycle pulse).
- spr_data_out  output  DATA_WIDTH  sprite response data.
- spr_valid_out  output  1  sprite response valid (1-cycle pulse).
- bg_req_in / bg_addr_in / bg_ack_out / bg_data_out / bg_valid_out  as sprite set, for the background fetcher.
- cpu_req_in / cpu_addr_in / cpu_ack_out / cpu_data_out / cpu_valid_out  as sprite set, for the CPU.
- sprite_hit_in  input  1  sprite fetch in progress; masks BG requests.
- cpu_blocked_in  input  1  PPU in mode 3; CPU may not access VRAM.
- mem_addr_out  output  ADDR_WIDTH  VRAM read address, registered.
- mem_req_out  output  1  VRAM read strobe (1-cycle pulse).
- mem_data_in  input  DATA_WIDTH  VRAM read data.
- mem_valid_in  input  1  VRAM read data valid.
- busy_out  output  1  arbiter not in IDLE.
- timeout_out  output  1  sticky: a timeout has occurred since reset.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE, owner=none, timer=0.
  - All outputs 0: acks, valids, data, mem_addr_out, mem_req_out, busy_out, timeout_out.
  - A reset mid-transaction aborts it; a late mem_valid_in after reset is ignored.
- States: IDLE, BUSY, BLOCKED_RESP.
- Requester handshake:
  - Requester holds req and addr stable until it sees ack.
  - ack pulses on the accept cycle.
  - Response (data + valid) pulses exactly once, on a later cycle.
  - data_out holds its last value when valid is low.
- Eligibility, evaluated in IDLE only:
  - spr: spr_req_in.
  - bg: bg_req_in & ~sprite_hit_in.
  - cpu: cpu_req_in.
  - Fixed priority spr > bg > cpu.
- IDLE → BUSY, when the winner is spr, bg, or cpu with cpu_blocked_in=0:
  - Register mem_addr_out ← winner addr.
  - Pulse mem_req_out and the winner's ack in the same registered cycle.
  - Record owner; timer ← 0.
- IDLE → BLOCKED_RESP, when the winner is cpu with cpu_blocked_in=1:
  - Pulse cpu_ack_out; no mem_req_out.
  - Next cycle: cpu_data_out ← BLOCKED_DATA, pulse cpu_valid_out, return to IDLE.
- BUSY:
  - timer increments each cycle.
  - On mem_valid_in: owner data_out ← mem_data_in, pulse owner valid, go to IDLE.
  - If timer = TIMEOUT-1 with mem_valid_in low: owner data_out ← BLOCKED_DATA, pulse owner valid, set timeout_out, go to IDLE.
  - mem_valid_in and timeout in the same cycle: mem_valid_in wins; timeout_out is not set.
- mem_valid_in while IDLE or BLOCKED_RESP: ignored.
- Throughput:
  - Accept at cycle N with memory latency L gives response at N+L.
  - The next accept is no earlier than cycle N+L+1, so there are no back-to-back grants inside a transaction.
- sprite_hit_in or cpu_blocked_in changing while BUSY does not affect the in-flight transaction.
- Starvation: BG and CPU may starve under continuous higher-priority requests. This is intended; the PPU timing guarantees gaps.
- busy_out = (state != IDLE), registered.

Test Plan:
- Reset during BUSY (bg read at 16'h9800, rst_in low for 1 cycle, then mem_valid_in=1):
  - All outputs 0.
  - No bg_valid_out.
  - state=IDLE.
- Simultaneous spr 16'h8010, bg 16'h9800, cpu 16'h8000; memory latency 2, returns 8'hA5 then 8'h3C:
  - spr_ack at N, spr_valid with 8'hA5 at N+2.
  - bg_ack at N+3, bg_valid with 8'h3C at N+5.
  - cpu acked only after both.
- sprite_hit_in=1 with only bg_req_in=1 for 5 cycles:
  - No bg_ack_out and no mem_req_out.
  - Drop sprite_hit_in → bg_ack_out on the next cycle.
- cpu_blocked_in=1, cpu_req 16'h8123:
  - cpu_ack_out, then one cycle later cpu_valid_out with 8'hFF.
  - mem_req_out stays 0.
- bg read and memory never responds (TIMEOUT=16):
  - bg_valid_out with 8'hFF exactly 16 cycles after accept.
  - timeout_out=1 and stays 1.
- Stale mem_valid_in pulse while IDLE, no requests: no valid output asserted; state remains IDLE.

Source files
------------

// File: rtl/ppu_vram_arbiter.sv
// Fixed-priority (spr > bg > cpu) single-outstanding VRAM read arbiter with CPU mode-3 lockout and response timeout.
// Latency: ack/mem_req one cycle after an IDLE request; response one cycle after mem_valid_in; no new grant until the response cycle.
module ppu_vram_arbiter #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    TIMEOUT      = 16,
    parameter logic [DATA_WIDTH-1:0] BLOCKED_DATA = 8'hFF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  spr_req_in,
    input  logic [ADDR_WIDTH-1:0] spr_addr_in,
    output logic                  spr_ack_out,
    output logic [DATA_WIDTH-1:0] spr_data_out,
    output logic                  spr_valid_out,
    input  logic                  bg_req_in,
    input  logic [ADDR_WIDTH-1:0] bg_addr_in,
    output logic                  bg_ack_out,
    output logic [DATA_WIDTH-1:0] bg_data_out,
    output logic                  bg_valid_out,
    input  logic                  cpu_req_in,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
    output logic                  cpu_ack_out,
    output logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic                  cpu_valid_out,
    input  logic                  sprite_hit_in,
    input  logic                  cpu_blocked_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_req_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_valid_in,
    output logic                  busy_out,
    output logic                  timeout_out
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_BLOCKED_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_SPR, OWN_BG, OWN_CPU} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic                  spr_ack_q, spr_ack_d, bg_ack_q, bg_ack_d, cpu_ack_q, cpu_ack_d;
    logic                  spr_vld_q, spr_vld_d, bg_vld_q, bg_vld_d, cpu_vld_q, cpu_vld_d;
    logic [DATA_WIDTH-1:0] spr_dat_q, spr_dat_d, bg_dat_q, bg_dat_d, cpu_dat_q, cpu_dat_d;
    logic                  busy_q, timeout_q, timeout_d;
    logic                  rsp_fire;
    logic [DATA_WIDTH-1:0] rsp_dat;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = 1'b0;
        spr_ack_d  = 1'b0;
        bg_ack_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        spr_vld_d  = 1'b0;
        bg_vld_d   = 1'b0;
        cpu_vld_d  = 1'b0;
        spr_dat_d  = spr_dat_q;
        bg_dat_d   = bg_dat_q;
        cpu_dat_d  = cpu_dat_q;
        timeout_d  = timeout_q;
        rsp_fire   = 1'b0;
        rsp_dat    = BLOCKED_DATA;

        case (state_q)
            S_IDLE: begin
                if (spr_req_in) begin
                    state_d    = S_BUSY;
                    owner_d    = OWN_SPR;
                    timer_d    = '0;
                    mem_addr_d = spr_addr_in;
                    mem_req_d  = 1'b1;
                    spr_ack_d  = 1'b1;
                end else if (bg_req_in && !sprite_hit_in) begin
                    state_d    = S_BUSY;
                    owner_d    = OWN_BG;
                    timer_d    = '0;
                    mem_addr_d = bg_addr_in;
                    mem_req_d  = 1'b1;
                    bg_ack_d   = 1'b1;
                end else if (cpu_req_in) begin
                    owner_d   = OWN_CPU;
                    cpu_ack_d = 1'b1;
                    if (cpu_blocked_in) begin
                        state_d = S_BLOCKED_RESP;
                    end else begin
                        state_d    = S_BUSY;
                        timer_d    = '0;
                        mem_addr_d = cpu_addr_in;
                        mem_req_d  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                timer_d = timer_q + TW'(1);
                // A response arriving on the last allowed cycle beats the timeout.
                if (mem_valid_in) begin
                    rsp_fire = 1'b1;
                    rsp_dat  = mem_data_in;
                    state_d  = S_IDLE;
                    owner_d  = OWN_NONE;
                end else if (timer_q == TMAX) begin
                    rsp_fire  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    owner_d   = OWN_NONE;
                end
            end
            S_BLOCKED_RESP: begin
                rsp_fire = 1'b1;
                state_d  = S_IDLE;
                owner_d  = OWN_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (rsp_fire) begin
            case (owner_q)
                OWN_SPR: begin spr_vld_d = 1'b1; spr_dat_d = rsp_dat; end
                OWN_BG:  begin bg_vld_d  = 1'b1; bg_dat_d  = rsp_dat; end
                OWN_CPU: begin cpu_vld_d = 1'b1; cpu_dat_d = rsp_dat; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            timer_q    <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            spr_ack_q  <= 1'b0;
            bg_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            spr_vld_q  <= 1'b0;
            bg_vld_q   <= 1'b0;
            cpu_vld_q  <= 1'b0;
            spr_dat_q  <= '0;
            bg_dat_q   <= '0;
            cpu_dat_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            timer_q    <= timer_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            spr_ack_q  <= spr_ack_d;
            bg_ack_q   <= bg_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            spr_vld_q  <= spr_vld_d;
            bg_vld_q   <= bg_vld_d;
            cpu_vld_q  <= cpu_vld_d;
            spr_dat_q  <= spr_dat_d;
            bg_dat_q   <= bg_dat_d;
            cpu_dat_q  <= cpu_dat_d;
            busy_q     <= (state_d != S_IDLE);
            timeout_q  <= timeout_d;
        end
    end

    assign spr_ack_out   = spr_ack_q;
    assign bg_ack_out    = bg_ack_q;
    assign cpu_ack_out   = cpu_ack_q;
    assign spr_valid_out = spr_vld_q;
    assign bg_valid_out  = bg_vld_q;
    assign cpu_valid_out = cpu_vld_q;
    assign spr_data_out  = spr_dat_q;
    assign bg_data_out   = bg_dat_q;
    assign cpu_data_out  = cpu_dat_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_req_out   = mem_req_q;
    assign busy_out      = busy_q;
    assign timeout_out   = timeout_q;
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: directed scenarios, then random traffic against a transaction-level timing model.
module tb_ppu_vram_arbiter;
    localparam int TO = 16;
    localparam int NC = 3000;
    localparam int NA = NC + TO + 8;

    logic        clk, rst_n;
    logic        spr_req, bg_req, cpu_req;
    logic [15:0] spr_addr, bg_addr, cpu_addr;
    logic        spr_ack, bg_ack, cpu_ack;
    logic [7:0]  spr_data, bg_data, cpu_data;
    logic        spr_vld, bg_vld, cpu_vld;
    logic        sprite_hit, cpu_blocked;
    logic [15:0] mem_addr;
    logic        mem_req, mem_valid, busy, tmo;
    logic [7:0]  mem_data;

    int n_chk = 0;
    int n_err = 0;

    ppu_vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(TO), .BLOCKED_DATA(8'hFF)) dut (
        .clk_in(clk), .rst_in(rst_n),
        .spr_req_in(spr_req), .spr_addr_in(spr_addr), .spr_ack_out(spr_ack),
        .spr_data_out(spr_data), .spr_valid_out(spr_vld),
        .bg_req_in(bg_req), .bg_addr_in(bg_addr), .bg_ack_out(bg_ack),
        .bg_data_out(bg_data), .bg_valid_out(bg_vld),
        .cpu_req_in(cpu_req), .cpu_addr_in(cpu_addr), .cpu_ack_out(cpu_ack),
        .cpu_data_out(cpu_data), .cpu_valid_out(cpu_vld),
        .sprite_hit_in(sprite_hit), .cpu_blocked_in(cpu_blocked),
        .mem_addr_out(mem_addr), .mem_req_out(mem_req),
        .mem_data_in(mem_data), .mem_valid_in(mem_valid),
        .busy_out(busy), .timeout_out(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".acks"}, {29'd0, spr_ack, bg_ack, cpu_ack}, 32'd0);
        chk({tag, ".vlds"}, {29'd0, spr_vld, bg_vld, cpu_vld}, 32'd0);
        chk({tag, ".data"}, {8'd0, spr_data, bg_data, cpu_data}, 32'd0);
        chk({tag, ".maddr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, ".mreq_busy_to"}, {29'd0, mem_req, busy, tmo}, 32'd0);
    endtask

    task automatic idle_inputs();
        spr_req = 0; bg_req = 0; cpu_req = 0;
        spr_addr = 0; bg_addr = 0; cpu_addr = 0;
        sprite_hit = 0; cpu_blocked = 0; mem_valid = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1;
    endtask

    // Random-phase timing model: per-cycle expectation tables filled at grant time.
    bit          e_ack [3][NA];
    bit          e_vld [3][NA];
    logic [7:0]  e_vdat[3][NA];
    bit          e_mreq[NA];
    logic [15:0] e_maddr[NA];
    bit          e_busy[NA];
    bit          e_toset[NA];
    bit          mv_s[NA];
    logic [7:0]  md_s[NA];

    initial begin
        logic [7:0]  last_dat[3];
        logic [15:0] last_maddr;
        bit          to_m, pend[3], cur_blk;
        logic [15:0] paddr[3];
        int          free_at, w, n, lat, r;
        logic [7:0]  d;

        rst_n = 1;
        idle_inputs();
        do_reset();

        // Priority ordering with memory latency 2.
        @(negedge clk);
        spr_req = 1; spr_addr = 16'h8010;
        bg_req = 1;  bg_addr = 16'h9800;
        cpu_req = 1; cpu_addr = 16'h8000;
        @(negedge clk);
        chk("pri.spr_ack", spr_ack, 1); chk("pri.mreq", mem_req, 1);
        chk("pri.maddr", mem_addr, 16'h8010); chk("pri.bg_ack0", bg_ack, 0);
        spr_req = 0;
        @(negedge clk);
        chk("pri.spr_vld_early", spr_vld, 0);
        mem_valid = 1; mem_data = 8'hA5;
        @(negedge clk);
        mem_valid = 0;
        chk("pri.spr_vld", spr_vld, 1); chk("pri.spr_dat", spr_data, 8'hA5);
        chk("pri.bg_ack_early", bg_ack, 0);
        @(negedge clk);
        chk("pri.bg_ack", bg_ack, 1); chk("pri.bg_maddr", mem_addr, 16'h9800);
        chk("pri.cpu_ack0", cpu_ack, 0);
        bg_req = 0;
        @(negedge clk);
        mem_valid = 1; mem_data = 8'h3C;
        chk("pri.cpu_ack1", cpu_ack, 0);
        @(negedge clk);
        mem_valid = 0;
        chk("pri.bg_vld", bg_vld, 1); chk("pri.bg_dat", bg_data, 8'h3C);
        chk("pri.cpu_ack2", cpu_ack, 0);
        @(negedge clk);
        chk("pri.cpu_ack", cpu_ack, 1); chk("pri.cpu_maddr", mem_addr, 16'h8000);
        cpu_req = 0; mem_valid = 1; mem_data = 8'h5A;
        @(negedge clk);
        mem_valid = 0;
        chk("pri.cpu_vld", cpu_vld, 1); chk("pri.cpu_dat", cpu_data, 8'h5A);

        // Reset in the middle of a bg transaction; late response must be ignored.
        bg_req = 1; bg_addr = 16'h9800;
        @(negedge clk);
        chk("rst.bg_ack", bg_ack, 1);
        bg_req = 0;
        rst_n = 0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1; mem_valid = 1; mem_data = 8'h11;
        @(negedge clk);
        mem_valid = 0;
        chk("rst.no_vld", bg_vld, 0); chk("rst.idle", busy, 0);
        chk("rst.bg_dat", bg_data, 0);

        // sprite_hit masks bg.
        sprite_hit = 1; bg_req = 1; bg_addr = 16'h9A00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hit.bg_ack0", bg_ack, 0); chk("hit.mreq0", mem_req, 0);
        end
        sprite_hit = 0;
        @(negedge clk);
        chk("hit.bg_ack", bg_ack, 1); chk("hit.maddr", mem_addr, 16'h9A00);
        bg_req = 0; mem_valid = 1; mem_data = 8'h42;
        @(negedge clk);
        mem_valid = 0;
        chk("hit.bg_vld", bg_vld, 1); chk("hit.bg_dat", bg_data, 8'h42);

        // CPU blocked in mode 3.
        cpu_blocked = 1; cpu_req = 1; cpu_addr = 16'h8123;
        @(negedge clk);
        chk("blk.ack", cpu_ack, 1); chk("blk.mreq", mem_req, 0); chk("blk.vld0", cpu_vld, 0);
        cpu_req = 0;
        @(negedge clk);
        chk("blk.vld", cpu_vld, 1); chk("blk.dat", cpu_data, 8'hFF); chk("blk.mreq2", mem_req, 0);
        cpu_blocked = 0;
        @(negedge clk);
        chk("blk.vld_pulse", cpu_vld, 0);

        // Timeout: memory never answers.
        bg_req = 1; bg_addr = 16'h9C00;
        @(negedge clk);
        chk("to.ack", bg_ack, 1);
        bg_req = 0;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            chk("to.vld_early", bg_vld, 0); chk("to.flag_early", tmo, 0);
        end
        @(negedge clk);
        chk("to.vld", bg_vld, 1); chk("to.dat", bg_data, 8'hFF); chk("to.flag", tmo, 1);
        repeat (3) begin
            @(negedge clk);
            chk("to.sticky", tmo, 1);
        end

        // Stale mem_valid while idle.
        mem_valid = 1; mem_data = 8'h77;
        @(negedge clk);
        mem_valid = 0;
        @(negedge clk);
        chk("stale.vlds", {spr_vld, bg_vld, cpu_vld}, 0);
        chk("stale.busy", busy, 0); chk("stale.bg_dat", bg_data, 8'hFF);

        // Random traffic.
        do_reset();
        for (int i = 0; i < NA; i++) begin
            for (int k = 0; k < 3; k++) begin
                e_ack[k][i] = 0; e_vld[k][i] = 0; e_vdat[k][i] = 0;
            end
            e_mreq[i] = 0; e_maddr[i] = 0; e_busy[i] = 0; e_toset[i] = 0;
            mv_s[i] = 0; md_s[i] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            last_dat[k] = 0; pend[k] = 0; paddr[k] = 0;
        end
        last_maddr = 0; to_m = 0; free_at = 0; cur_blk = 0;

        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (e_vld[k][c]) last_dat[k] = e_vdat[k][c];
            if (e_mreq[c]) last_maddr = e_maddr[c];
            if (e_toset[c]) to_m = 1;
            chk("rnd.spr_ack", spr_ack, e_ack[0][c]);
            chk("rnd.bg_ack",  bg_ack,  e_ack[1][c]);
            chk("rnd.cpu_ack", cpu_ack, e_ack[2][c]);
            chk("rnd.spr_vld", spr_vld, e_vld[0][c]);
            chk("rnd.bg_vld",  bg_vld,  e_vld[1][c]);
            chk("rnd.cpu_vld", cpu_vld, e_vld[2][c]);
            chk("rnd.data", {spr_data, bg_data, cpu_data}, {last_dat[0], last_dat[1], last_dat[2]});
            chk("rnd.mreq", mem_req, e_mreq[c]);
            chk("rnd.maddr", mem_addr, last_maddr);
            chk("rnd.busy", busy, e_busy[c]);
            chk("rnd.timeout", tmo, to_m);

            for (int k = 0; k < 3; k++) begin
                if (e_ack[k][c]) pend[k] = 0;
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1;
                    paddr[k] = 16'($urandom);
                end
            end
            spr_req = pend[0]; spr_addr = paddr[0];
            bg_req  = pend[1]; bg_addr  = paddr[1];
            cpu_req = pend[2]; cpu_addr = paddr[2];
            sprite_hit  = ($urandom_range(0, 3) == 0);
            cpu_blocked = ($urandom_range(0, 2) == 0);
            mem_valid = mv_s[c];
            mem_data  = mv_s[c] ? md_s[c] : 8'($urandom);
            if ((c >= free_at || cur_blk) && $urandom_range(0, 7) == 0)
                mem_valid = 1;

            if (c >= free_at) begin
                w = -1;
                if (pend[0]) w = 0;
                else if (pend[1] && !sprite_hit) w = 1;
                else if (pend[2]) w = 2;
                if (w >= 0) begin
                    n = c + 1;
                    e_ack[w][n] = 1;
                    if (w == 2 && cpu_blocked) begin
                        cur_blk = 1;
                        r = n + 1;
                        d = 8'hFF;
                    end else begin
                        cur_blk = 0;
                        e_mreq[n] = 1;
                        e_maddr[n] = paddr[w];
                        lat = $urandom_range(1, TO + 3);
                        if (lat <= TO) begin
                            r = n + lat;
                            d = 8'($urandom);
                            mv_s[r - 1] = 1;
                            md_s[r - 1] = d;
                        end else begin
                            r = n + TO;
                            d = 8'hFF;
                            e_toset[r] = 1;
                        end
                    end
                    e_vld[w][r] = 1;
                    e_vdat[w][r] = d;
                    for (int t = n; t < r; t++) e_busy[t] = 1;
                    free_at = r;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
